// File: rtl/rsnn_frontend_pkg.sv
// Shared defaults and mode encodings for the RSNN spike input front end.
package rsnn_frontend_pkg;

    localparam int DEF_N_CH        = 3;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 4;

    // Values of the edge_mode input.
    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;

endpackage

// File: rtl/sync_chain.sv
// Multi-bit flip-flop synchroniser. Each bit is an independent async line.
// STAGES must be at least 2; the output is the last stage of the chain.
module sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [STAGES-1:0][WIDTH-1:0] stage_r;

    // Shift the raw inputs through the synchroniser stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_r <= '0;
        end else begin
            stage_r <= {stage_r[STAGES-2:0], din};
        end
    end

    assign dout = stage_r[STAGES-1];

endmodule

// File: rtl/spike_input_frontend.sv
// Spike input front end: synchronises enables and spike lines, detects
// level/edge events, buffers them in a pending vector handed over with a
// valid/ready handshake, and keeps per-channel saturating drop statistics.
module spike_input_frontend
    import rsnn_frontend_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  system_enable,
    input  logic                  capture_enable,
    input  logic                  rsnn_enable,
    input  logic                  edge_mode,
    input  logic [N_CH-1:0]       spikes_async,
    input  logic                  spike_ready,
    input  logic                  clear_stats,
    output logic                  sync_system_enable,
    output logic                  rsnn_enable_comb,
    output logic [N_CH-1:0]       spikes_out,
    output logic                  spike_valid,
    output logic [N_CH*CNT_W-1:0] drop_count,
    output logic [N_CH-1:0]       overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Bit 0 = system, bit 1 = capture, bit 2 = rsnn.
    logic [2:0]                 en_sync_s;
    logic [N_CH-1:0]            sync_spk_s;
    logic [N_CH-1:0]            prev_r;
    logic [N_CH-1:0]            spk_event_s;
    logic [N_CH-1:0]            cap_event_s;
    logic [N_CH-1:0]            pend_r;
    logic [N_CH-1:0]            pend_next_s;
    logic [N_CH-1:0]            drop_s;
    logic                       valid_r;
    logic                       capture_active_s;
    logic                       consume_s;
    logic [N_CH-1:0][CNT_W-1:0] cnt_r;
    logic [N_CH-1:0][CNT_W-1:0] cnt_next_s;
    logic [N_CH-1:0]            ovf_r;
    logic [N_CH-1:0]            ovf_next_s;

    sync_chain #(.WIDTH(3), .STAGES(SYNC_STAGES)) u_sync_en (
        .clk   (clk),
        .reset (reset),
        .din   ({rsnn_enable, capture_enable, system_enable}),
        .dout  (en_sync_s)
    );

    sync_chain #(.WIDTH(N_CH), .STAGES(SYNC_STAGES)) u_sync_spk (
        .clk   (clk),
        .reset (reset),
        .din   (spikes_async),
        .dout  (sync_spk_s)
    );

    assign capture_active_s = en_sync_s[0] & en_sync_s[1];
    // valid_r mirrors |pend_r, so the handshake never sees spike_ready combinationally.
    assign consume_s        = valid_r & spike_ready;

    // Per-channel event detection in the selected mode.
    always_comb begin
        spk_event_s = '0;
        if (edge_mode == MODE_LEVEL) begin
            spk_event_s = sync_spk_s;
        end else begin
            spk_event_s = sync_spk_s & ~prev_r;
        end
    end

    assign cap_event_s = spk_event_s & {N_CH{capture_active_s}};
    assign drop_s      = cap_event_s & pend_r & {N_CH{~consume_s}};

    // Next pending vector: consumed bits clear, new events always merge in.
    always_comb begin
        pend_next_s = '0;
        if (!en_sync_s[0]) begin
            pend_next_s = '0;
        end else if (consume_s) begin
            pend_next_s = cap_event_s;
        end else begin
            pend_next_s = pend_r | cap_event_s;
        end
    end

    // Next drop counters and sticky overflow flags; clear_stats wins.
    always_comb begin
        cnt_next_s = cnt_r;
        ovf_next_s = ovf_r;
        if (clear_stats) begin
            cnt_next_s = '0;
            ovf_next_s = '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (drop_s[i]) begin
                    if (cnt_r[i] == CNT_MAX) begin
                        ovf_next_s[i] = 1'b1;
                    end else begin
                        cnt_next_s[i] = cnt_r[i] + CNT_ONE;
                    end
                end else begin
                    cnt_next_s[i] = cnt_r[i];
                end
            end
        end
    end

    // Edge history tracks the synchronised lines every cycle, regardless of capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_r <= '0;
        end else begin
            prev_r <= sync_spk_s;
        end
    end

    // Pending vector and its registered valid flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_r  <= '0;
            valid_r <= 1'b0;
        end else begin
            pend_r  <= pend_next_s;
            valid_r <= |pend_next_s;
        end
    end

    // Drop statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
            ovf_r <= '0;
        end else begin
            cnt_r <= cnt_next_s;
            ovf_r <= ovf_next_s;
        end
    end

    assign sync_system_enable = en_sync_s[0];
    assign rsnn_enable_comb   = en_sync_s[0] & en_sync_s[2];
    assign spikes_out         = pend_r;
    assign spike_valid        = valid_r;
    assign drop_count         = cnt_r;
    assign overflow           = ovf_r;

endmodule

// File: tb/tb_spike_input_frontend.sv
// Directed self-checking bench for spike_input_frontend (N_CH=3, 2 stages, 4-bit counters).
module tb_spike_input_frontend;

    localparam int N_CH  = 3;
    localparam int SS    = 2;
    localparam int CNT_W = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  system_enable;
    logic                  capture_enable;
    logic                  rsnn_enable;
    logic                  edge_mode;
    logic [N_CH-1:0]       spikes_async;
    logic                  spike_ready;
    logic                  clear_stats;
    logic                  sync_system_enable;
    logic                  rsnn_enable_comb;
    logic [N_CH-1:0]       spikes_out;
    logic                  spike_valid;
    logic [N_CH*CNT_W-1:0] drop_count;
    logic [N_CH-1:0]       overflow;

    int n_checks = 0;
    int n_errors = 0;
    int vcount;

    spike_input_frontend #(.N_CH(N_CH), .SYNC_STAGES(SS), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .reset              (reset),
        .system_enable      (system_enable),
        .capture_enable     (capture_enable),
        .rsnn_enable        (rsnn_enable),
        .edge_mode          (edge_mode),
        .spikes_async       (spikes_async),
        .spike_ready        (spike_ready),
        .clear_stats        (clear_stats),
        .sync_system_enable (sync_system_enable),
        .rsnn_enable_comb   (rsnn_enable_comb),
        .spikes_out         (spikes_out),
        .spike_valid        (spike_valid),
        .drop_count         (drop_count),
        .overflow           (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; inputs change and outputs are sampled 1 time unit later.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-sample pulse on the spike lines, then wait until the event has landed in pend.
    task automatic pulse(input logic [N_CH-1:0] v);
        spikes_async = v;
        tick(1);
        spikes_async = '0;
        tick(2);
    endtask

    initial begin
        reset          = 1'b1;
        system_enable  = 1'b1;
        capture_enable = 1'b1;
        rsnn_enable    = 1'b1;
        edge_mode      = 1'b1;
        spikes_async   = 3'b010;
        spike_ready    = 1'b0;
        clear_stats    = 1'b0;

        // Reset holds everything at zero even with inputs active.
        tick(3);
        check_val("rst_valid", {31'd0, spike_valid}, 32'd0);
        check_val("rst_spikes", {29'd0, spikes_out}, 32'd0);
        check_val("rst_sysen", {31'd0, sync_system_enable}, 32'd0);
        check_val("rst_rsnnen", {31'd0, rsnn_enable_comb}, 32'd0);
        check_val("rst_drops", {20'd0, drop_count}, 32'd0);
        check_val("rst_ovf", {29'd0, overflow}, 32'd0);

        spikes_async = 3'b000;
        reset = 1'b0;
        tick(1);
        check_val("sysen_lat1", {31'd0, sync_system_enable}, 32'd0);
        tick(1);
        check_val("sysen_lat2", {31'd0, sync_system_enable}, 32'd1);
        check_val("rsnnen_on", {31'd0, rsnn_enable_comb}, 32'd1);
        tick(2);

        // Test 1: edge on ch1 first sampled at edge k -> valid after edge k+2.
        spikes_async = 3'b010;
        tick(1);
        check_val("lat_k", {31'd0, spike_valid}, 32'd0);
        tick(1);
        check_val("lat_k1", {31'd0, spike_valid}, 32'd0);
        tick(1);
        check_val("lat_k2_valid", {31'd0, spike_valid}, 32'd1);
        check_val("lat_k2_spikes", {29'd0, spikes_out}, 32'd2);

        // Test 2: consume 010 in the same cycle a new ch0 edge is detected.
        spikes_async = 3'b011;
        tick(2);
        spike_ready = 1'b1;
        tick(1);
        check_val("hs_spikes", {29'd0, spikes_out}, 32'd1);
        check_val("hs_valid", {31'd0, spike_valid}, 32'd1);
        check_val("hs_drops", {20'd0, drop_count}, 32'd0);
        tick(1);
        check_val("hs_drained", {31'd0, spike_valid}, 32'd0);
        spikes_async = 3'b000;
        spike_ready  = 1'b0;
        tick(3);

        // Test 3: one ch2 edge fills pend, then 15 drops saturate, the 16th overflows.
        for (int n = 0; n < 16; n++) begin
            pulse(3'b100);
        end
        check_val("sat_count15", {20'd0, drop_count}, 32'h0F00);
        check_val("sat_ovf_clear", {29'd0, overflow}, 32'd0);
        pulse(3'b100);
        check_val("sat_ovf_set", {29'd0, overflow}, 32'd4);
        check_val("sat_count_hold", {20'd0, drop_count}, 32'h0F00);
        check_val("sat_pend", {29'd0, spikes_out}, 32'd4);
        clear_stats = 1'b1;
        tick(1);
        clear_stats = 1'b0;
        check_val("clr_count", {20'd0, drop_count}, 32'd0);
        check_val("clr_ovf", {29'd0, overflow}, 32'd0);
        check_val("clr_pend", {29'd0, spikes_out}, 32'd4);
        spike_ready = 1'b1;
        tick(1);
        check_val("drain3", {31'd0, spike_valid}, 32'd0);

        // Test 4: held line for 5 samples, level mode then edge mode.
        capture_enable = 1'b0;
        tick(3);
        edge_mode = 1'b0;
        capture_enable = 1'b1;
        tick(3);
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            spikes_async = (i < 5) ? 3'b001 : 3'b000;
            tick(1);
            if (spike_valid) vcount++;
        end
        check_val("level_vectors", vcount, 32'd5);
        capture_enable = 1'b0;
        tick(3);
        edge_mode = 1'b1;
        capture_enable = 1'b1;
        tick(3);
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            spikes_async = (i < 5) ? 3'b001 : 3'b000;
            tick(1);
            if (spike_valid) vcount++;
        end
        check_val("edge_vectors", vcount, 32'd1);
        check_val("level_edge_drops", {20'd0, drop_count}, 32'd0);
        spike_ready = 1'b0;

        // Test 5: enabling capture over already-high lines gives no edge.
        capture_enable = 1'b0;
        tick(1);
        spikes_async = 3'b111;
        tick(4);
        capture_enable = 1'b1;
        tick(4);
        check_val("gate_no_event", {31'd0, spike_valid}, 32'd0);
        spikes_async = 3'b000;
        tick(3);
        pulse(3'b101);
        check_val("gate_pend", {29'd0, spikes_out}, 32'd5);
        system_enable = 1'b0;
        tick(2);
        check_val("sysoff_hold", {29'd0, spikes_out}, 32'd5);
        tick(1);
        check_val("sysoff_pend", {29'd0, spikes_out}, 32'd0);
        check_val("sysoff_valid", {31'd0, spike_valid}, 32'd0);
        check_val("sysoff_rsnnen", {31'd0, rsnn_enable_comb}, 32'd0);

        // Test 6: asynchronous reset mid-stream clears outputs without a clock edge.
        system_enable = 1'b1;
        tick(3);
        pulse(3'b110);
        check_val("pre_rst_pend", {29'd0, spikes_out}, 32'd6);
        #2;
        reset = 1'b1;
        #1;
        check_val("async_rst_spikes", {29'd0, spikes_out}, 32'd0);
        check_val("async_rst_valid", {31'd0, spike_valid}, 32'd0);
        check_val("async_rst_sysen", {31'd0, sync_system_enable}, 32'd0);
        tick(2);
        reset = 1'b0;
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (spike_valid) vcount++;
        end
        check_val("post_rst_quiet", vcount, 32'd0);
        pulse(3'b010);
        check_val("post_rst_event", {29'd0, spikes_out}, 32'd2);
        check_val("post_rst_valid", {31'd0, spike_valid}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
